pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Pipeline sequencer for the 5-stage RV32I core. It sits beside if_id / id / id_ex / ex and owns every hold, flush and PC-redirect decision.
- It handles three events:
  - branch/jump redirects from ex, which flush the younger stages;
  - load-use hazards between the id source addresses and a load in id_ex, which insert one bubble;
  - multi-cycle data-bus accesses, which freeze the front end until acknowledged or timed out.
- It also keeps a saturating stall-cycle performance counter.

Parameters:
- BUS_TIMEOUT, 255: number of BUS_WAIT cycles before a pending bus access is abandoned. Legal range 1..255.
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- jump_en_i  in  1  ex resolves a taken branch/JAL/JALR this cycle
- jump_addr_i  in  32  redirect target from ex
- id_rs1_addr_i  in  5  rs1 address driven by id (0 = unused)
- id_rs2_addr_i  in  5  rs2 address driven by id (0 = unused)
- ex_rd_addr_i  in  5  rd of instruction held in id_ex
- ex_is_load_i  in  1  instruction in id_ex is a load
- bus_req_i  in  1  mem access in progress needs the bus
- bus_ack_i  in  1  bus completes access this cycle
- hold_pc_o  out  1  pc register keeps value
- hold_if_id_o  out  1  if_id keeps contents
- hold_id_ex_o  out  1  id_ex keeps contents
- flush_if_id_o  out  1  if_id loads NOP next edge
- flush_id_ex_o  out  1  id_ex loads NOP next edge
- jump_en_o  out  1  pc loads jump_addr_o next edge
- jump_addr_o  out  32  redirect target to pc
- bus_timeout_o  out  1  one-cycle pulse: bus access abandoned
- stall_cnt_o  out  CNT_W  count of cycles with hold_pc_o=1, saturating

Behaviour:

Reset and output style:
- While rst=0, asynchronously: state=RUN, wait_cnt=0, bus_timeout_o=0, stall_cnt_o=0.
- All combinational outputs are forced to 0 during reset, and jump_addr_o=0.
- Outputs are Mealy: they are decoded combinationally from the state and the current inputs. The exception is bus_timeout_o, which is registered. The decision takes effect in the same cycle, with no added latency.
- Reset mid-BUS_WAIT: abandons the wait silently; no timeout pulse.

State RUN. Conditions are evaluated in priority order; the first match applies.
1. bus_timeout_o=1 (the cycle right after a timeout): bus_req_i is ignored and evaluation continues with rule 3.
2. bus_req_i=1 and bus_ack_i=0:
   - outputs: hold_pc, hold_if_id, hold_id_ex = 1; no flush; jump_en_o=0;
   - wait_cnt<=0; next state BUS_WAIT.
   - A jump is not lost, because ex is frozen and re-presents it after release.
3. jump_en_i=1:
   - outputs: jump_en_o=1, jump_addr_o=jump_addr_i, flush_if_id_o=1, flush_id_ex_o=1; no holds;
   - stay in RUN.
   - A jump overrides a simultaneous load-use hazard, because the hazard instruction is squashed.
4. Load-use hazard, defined as ex_is_load_i=1 AND ex_rd_addr_i!=0 AND ex_rd_addr_i matches a nonzero id_rs1_addr_i or id_rs2_addr_i:
   - outputs: hold_pc=1, hold_if_id=1, flush_id_ex=1 (bubble);
   - next state LOAD_USE.
5. Otherwise: all outputs 0; stay in RUN.

State LOAD_USE. Lasts exactly one cycle; the hazard check is suppressed because id_ex now holds the bubble.
- A jump cannot occur here, since ex holds a NOP.
- bus_req_i=1 and bus_ack_i=0: handled as rule 2 in RUN, going to BUS_WAIT.
- Otherwise: outputs 0; next state RUN.

State BUS_WAIT:
- bus_ack_i=1: all holds 0 this cycle; next state RUN.
- Else, if wait_cnt==BUS_TIMEOUT-1:
  - holds stay 1 this cycle;
  - next state RUN; bus_timeout_o<=1 for exactly the next cycle.
- Else: holds 1; wait_cnt<=wait_cnt+1.
- jump_en_i is ignored in this state.
- Total hold length on timeout = BUS_TIMEOUT+1 cycles (entry cycle plus BUS_TIMEOUT).

Counters and encoding:
- wait_cnt is 8 bits.
- stall_cnt_o increments on every edge where hold_pc_o=1 and stops at all-ones (no wrap).
- State is a 2-bit encoding; the unused code recovers to RUN with outputs 0.

Decomposition:
- defines.v (shared) gains:
  - state encodings CTRL_RUN, CTRL_LOAD_USE, CTRL_BUS_WAIT;
  - constant ZERO_REG = 5'd0.
- Sub-module sat_counter (parameter W; inputs en, rst; output count) implements stall_cnt_o and is reusable for the other performance counters.
- The FSM and hazard compare stay in pipe_ctrl.

Test Plan:
1. Load-use: ex_is_load_i=1, ex_rd_addr_i=5, id_rs2_addr_i=5 -> one cycle with hold_pc=1, hold_if_id=1, flush_id_ex=1, then all 0; stall_cnt_o=1. The same stimulus with ex_rd_addr_i=0 gives no stall.
2. Jump plus hazard in the same cycle: jump_en_i=1, jump_addr_i=32'h0000_0100, load-use active -> jump_en_o=1, jump_addr_o=32'h100, both flushes=1, hold_pc=0; state stays RUN.
3. Bus wait with ack: bus_req_i=1, ack on the 3rd cycle after entry -> holds high for 3 cycles and low in the ack cycle; stall_cnt_o=3; no bus_timeout_o.
4. Timeout: BUS_TIMEOUT=4, bus_req_i held at 1 and never acked -> holds high for 5 cycles; then bus_timeout_o=1 for one cycle, during which the still-high bus_req_i does not re-enter BUS_WAIT.
5. Jump while frozen: jump_en_i=1 throughout BUS_WAIT -> jump_en_o=0 until the ack cycle has passed, then jump_en_o=1 on the first RUN cycle.
6. Reset mid-wait: rst dropped during BUS_WAIT -> all outputs 0 immediately; after rst rises, state RUN, stall_cnt_o=0, no timeout pulse.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encodings,
// the hard-wired zero register index and the source/destination compare.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN      = 2'b00,
        CTRL_LOAD_USE = 2'b01,
        CTRL_BUS_WAIT = 2'b10
    } ctrl_state_e;

    localparam logic [4:0] ZERO_REG = 5'd0;

    // A source operand depends on rd only when it names a real register.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] rd);
        return (src != ZERO_REG) && (src == rd);
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for performance counters; stops at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: step only when enabled and not yet saturated.
    always_comb begin
        count_d = count_q;
        if (en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register, cleared asynchronously by active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: owns hold, flush and PC-redirect decisions for the
// 5-stage core. Outputs are Mealy-decoded from state and current inputs;
// only the bus timeout pulse is registered.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_en_i,
    input  logic [31:0]      jump_addr_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_is_load_i,
    input  logic             bus_req_i,
    input  logic             bus_ack_i,
    output logic             hold_pc_o,
    output logic             hold_if_id_o,
    output logic             hold_id_ex_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             jump_en_o,
    output logic [31:0]      jump_addr_o,
    output logic             bus_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [7:0] WAIT_LAST = 8'(BUS_TIMEOUT - 1);

    ctrl_state_e state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        bus_timeout_q, bus_timeout_d;

    logic load_use_hazard;
    logic bus_stall;

    assign load_use_hazard = ex_is_load_i && (ex_rd_addr_i != ZERO_REG) &&
                             (reg_match(id_rs1_addr_i, ex_rd_addr_i) ||
                              reg_match(id_rs2_addr_i, ex_rd_addr_i));
    assign bus_stall = bus_req_i && !bus_ack_i;

    // Next-state and Mealy output decode; reset forces every decoded output low.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        bus_timeout_d = 1'b0;
        hold_pc_o     = 1'b0;
        hold_if_id_o  = 1'b0;
        hold_id_ex_o  = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        jump_en_o     = 1'b0;
        jump_addr_o   = '0;

        case (state_q)
            CTRL_RUN: begin
                // The cycle after a timeout ignores the still-pending request
                // so the front end gets one cycle of progress.
                if (bus_stall && !bus_timeout_q) begin
                    hold_pc_o    = 1'b1;
                    hold_if_id_o = 1'b1;
                    hold_id_ex_o = 1'b1;
                    wait_cnt_d   = '0;
                    state_d      = CTRL_BUS_WAIT;
                end else if (jump_en_i) begin
                    jump_en_o     = 1'b1;
                    jump_addr_o   = jump_addr_i;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                end else if (load_use_hazard) begin
                    hold_pc_o     = 1'b1;
                    hold_if_id_o  = 1'b1;
                    flush_id_ex_o = 1'b1;
                    state_d       = CTRL_LOAD_USE;
                end
            end
            CTRL_LOAD_USE: begin
                if (bus_stall) begin
                    hold_pc_o    = 1'b1;
                    hold_if_id_o = 1'b1;
                    hold_id_ex_o = 1'b1;
                    wait_cnt_d   = '0;
                    state_d      = CTRL_BUS_WAIT;
                end else begin
                    state_d = CTRL_RUN;
                end
            end
            CTRL_BUS_WAIT: begin
                if (bus_ack_i) begin
                    state_d = CTRL_RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    hold_pc_o     = 1'b1;
                    hold_if_id_o  = 1'b1;
                    hold_id_ex_o  = 1'b1;
                    bus_timeout_d = 1'b1;
                    state_d       = CTRL_RUN;
                end else begin
                    hold_pc_o    = 1'b1;
                    hold_if_id_o = 1'b1;
                    hold_id_ex_o = 1'b1;
                    wait_cnt_d   = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = CTRL_RUN;
            end
        endcase

        if (!rst) begin
            hold_pc_o     = 1'b0;
            hold_if_id_o  = 1'b0;
            hold_id_ex_o  = 1'b0;
            flush_if_id_o = 1'b0;
            flush_id_ex_o = 1'b0;
            jump_en_o     = 1'b0;
            jump_addr_o   = '0;
        end
    end

    // State, wait counter and registered timeout pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= CTRL_RUN;
            wait_cnt_q    <= '0;
            bus_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            bus_timeout_q <= bus_timeout_d;
        end
    end

    assign bus_timeout_o = bus_timeout_q;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (hold_pc_o),
        .count(stall_cnt_o)
    );

endmodule
